// File: rtl/pipe_share_pkg.sv
// Shared constants and helpers for the pipe-share arbiter.
// Also holds the parameter range checks used by the top.
package pipe_share_pkg;

  localparam int MAX_REQ = 16;
  localparam int MAX_LAT = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Tag id width, sized for the largest legal requester count.
  localparam int ID_W = clog2(MAX_REQ);

  function automatic bit params_ok(
    input int num_req,
    input int lat
  );
    return (num_req >= 2) && (num_req <= MAX_REQ) &&
           (lat >= 1) && (lat <= MAX_LAT);
  endfunction

endpackage

// File: rtl/pipe_share_arbiter_rr_arbiter.sv
// Round-robin grant logic and rr_ptr for the pipe-share arbiter.
// Grant is combinational; the pointer advances past each accepted winner.
module rr_arbiter
  import pipe_share_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               block,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] rot;
  logic               found;
  int                 sum;

  // Rotate so bit 0 is rr_ptr; scanning downward leaves the nearest hit.
  always_comb begin
    rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    found = 1'b0;
    sum = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        sum = int'(rr_ptr) + i;
      end
    end
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    grant_id = ID_W'(sum);
    grant_valid = found & ~block;
    grant = NUM_REQ'(grant_valid) << grant_id;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      if (int'(grant_id) == NUM_REQ - 1) rr_ptr <= '0;
      else rr_ptr <= grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Shares one fixed-latency datapath among NUM_REQ requesters and
// steers each result back to its owner through a tag pipeline.
module pipe_share_arbiter
  import pipe_share_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BIT_WIDTH = 10,
  parameter int LATENCY   = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           dp_valid,
  output logic [BIT_WIDTH-1:0]           dp_data,
  input  logic [BIT_WIDTH-1:0]           dp_result,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [BIT_WIDTH-1:0]           rsp_data,
  output logic [clog2(LATENCY+1)-1:0]    inflight
);

  if (!params_ok(NUM_REQ, LATENCY)) begin : g_bad_params
    $error("pipe_share_arbiter: NUM_REQ or LATENCY out of range");
  end

  logic [ID_W-1:0]    gid;
  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [LATENCY];
  logic               retire;

  // Reset also blocks grants so nothing issues while reset_n is low.
  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .block      (flush | ~reset_n),
    .req_valid  (req_valid),
    .grant      (req_ready),
    .grant_id   (gid),
    .grant_valid(dp_valid)
  );

  always_comb begin
    dp_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k]) dp_data = req_data[k*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0] <= dp_valid & ~flush;
      tag_id[0] <= gid;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1] & ~flush;
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign retire    = tag_v[LATENCY-1];
  assign rsp_valid = NUM_REQ'(retire) << tag_id[LATENCY-1];
  assign rsp_data  = dp_result;

  // Tracks the number of valid tags; issue and retire together cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else if (dp_valid && !retire) begin
      inflight <= inflight + 1'b1;
    end else if (!dp_valid && retire) begin
      inflight <= inflight - 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Scoreboard bench for pipe_share_arbiter: LATENCY=3 and LATENCY=1 instances
// with inverting datapath models; responses checked by decoupled monitors.
module tb_pipe_share_arbiter;

  typedef struct {
    int         id;
    logic [9:0] d;
    int         due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        flush1 = 1'b0;
  int          cyc_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [3:0]  rv0, rr0, sv0;
  logic [39:0] rd0;
  logic        dv0;
  logic [9:0]  dd0, dr0, sd0;
  logic [1:0]  inf0;

  logic [3:0]  rv1, rr1, sv1;
  logic [39:0] rd1;
  logic        dv1;
  logic [9:0]  dd1, dr1, sd1;
  logic [0:0]  inf1;

  logic [9:0]  dpp [3];
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  pipe_share_arbiter #(.NUM_REQ(4), .BIT_WIDTH(10), .LATENCY(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(rv0), .req_data(rd0), .req_ready(rr0),
    .dp_valid(dv0), .dp_data(dd0), .dp_result(dr0),
    .rsp_valid(sv0), .rsp_data(sd0), .inflight(inf0)
  );

  pipe_share_arbiter #(.NUM_REQ(4), .BIT_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush1),
    .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
    .dp_valid(dv1), .dp_data(dd1), .dp_result(dr1),
    .rsp_valid(sv1), .rsp_data(sd1), .inflight(inf1)
  );

  // Datapath models: bitwise invert, fixed latency.
  always @(posedge clk) begin
    dpp[0] <= ~dd0;
    dpp[1] <= dpp[0];
    dpp[2] <= dpp[1];
    dr1 <= ~dd1;
  end
  assign dr0 = dpp[2];

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp,
               cyc_cnt);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (sv0 != 4'b0) begin
        if (q0.size() == 0) begin
          chk("rsp0_unexpected", 32'(sv0), 32'h0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("rsp0_valid", 32'(sv0), 32'(4'b0001 << e.id));
          chk("rsp0_data", 32'(sd0), 32'(e.d));
          chk("rsp0_cycle", cyc_cnt, e.due);
        end
      end else if (q0.size() > 0 && q0[0].due < cyc_cnt) begin
        chk("rsp0_missing", cyc_cnt, q0[0].due);
        void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (sv1 != 4'b0) begin
        if (q1.size() == 0) begin
          chk("rsp1_unexpected", 32'(sv1), 32'h0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("rsp1_valid", 32'(sv1), 32'(4'b0001 << e.id));
          chk("rsp1_data", 32'(sd1), 32'(e.d));
          chk("rsp1_cycle", cyc_cnt, e.due);
        end
      end else if (q1.size() > 0 && q1[0].due < cyc_cnt) begin
        chk("rsp1_missing", cyc_cnt, q1[0].due);
        void'(q1.pop_front());
      end
    end
  end

  task automatic cyc0(input logic [3:0] v, input logic [39:0] d,
                      input logic [3:0] eg, input int ei, input logic fl);
    logic [9:0] ed;
    int         gi;
    rv0 = v;
    rd0 = d;
    flush = fl;
    #1;
    ed = '0;
    gi = 0;
    for (int k = 0; k < 4; k++) begin
      if (eg[k]) begin
        gi = k;
        ed = d[k*10 +: 10];
      end
    end
    chk("req_ready0", 32'(rr0), 32'(eg));
    chk("dp_valid0", 32'(dv0), 32'(|eg));
    chk("dp_data0", 32'(dd0), 32'(ed));
    chk("inflight0", 32'(inf0), ei);
    if (|eg) q0.push_back('{gi, ~ed, cyc_cnt + 3});
    @(posedge clk);
    #1;
    if (fl) q0.delete();
    flush = 1'b0;
  endtask

  task automatic cyc1(input logic [3:0] v, input logic [39:0] d,
                      input logic [3:0] eg, input int ei);
    logic [9:0] ed;
    int         gi;
    rv1 = v;
    rd1 = d;
    #1;
    ed = '0;
    gi = 0;
    for (int k = 0; k < 4; k++) begin
      if (eg[k]) begin
        gi = k;
        ed = d[k*10 +: 10];
      end
    end
    chk("req_ready1", 32'(rr1), 32'(eg));
    chk("dp_data1", 32'(dd1), 32'(ed));
    chk("inflight1", 32'(inf1), ei);
    if (|eg) q1.push_back('{gi, ~ed, cyc_cnt + 1});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0] d;
    rv0 = 4'hF;
    rd0 = '0;
    rv1 = 4'h0;
    rd1 = '0;
    #3;
    chk("rst_req_ready", 32'(rr0), 32'h0);
    chk("rst_dp_valid", 32'(dv0), 32'h0);
    chk("rst_rsp_valid", 32'(sv0), 32'h0);
    chk("rst_inflight", 32'(inf0), 32'h0);
    chk("rst_rsp_valid1", 32'(sv1), 32'h0);
    rv0 = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #4 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Full contention: strict rotation, inflight saturates at 3.
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 4; k++) d[k*10 +: 10] = 10'(37 * j + 5 * k + 1);
      cyc0(4'hF, d, 4'b0001 << (j % 4), (j < 3) ? j : 3, 1'b0);
    end
    cyc0(4'h0, '0, 4'h0, 3, 1'b0);
    cyc0(4'h0, '0, 4'h0, 2, 1'b0);
    cyc0(4'h0, '0, 4'h0, 1, 1'b0);
    cyc0(4'h0, '0, 4'h0, 0, 1'b0);

    // Single requester 2, operand 0x155 -> result 0x2AA.
    d = {10'h3C3, 10'h155, 10'h0AA, 10'h3FF};
    cyc0(4'b0100, d, 4'b0100, 0, 1'b0);
    cyc0(4'h0, '0, 4'h0, 1, 1'b0);
    cyc0(4'h0, '0, 4'h0, 1, 1'b0);
    cyc0(4'h0, '0, 4'h0, 1, 1'b0);
    cyc0(4'h0, '0, 4'h0, 0, 1'b0);

    // Three issues then flush; rr_ptr must survive the flush.
    d = {10'h111, 10'h222, 10'h333, 10'h044};
    cyc0(4'hF, d, 4'b1000, 0, 1'b0);
    cyc0(4'hF, d, 4'b0001, 1, 1'b0);
    cyc0(4'hF, d, 4'b0010, 2, 1'b0);
    cyc0(4'hF, d, 4'b0000, 3, 1'b1);
    cyc0(4'h0, '0, 4'h0, 0, 1'b0);
    cyc0(4'h0, '0, 4'h0, 0, 1'b0);
    cyc0(4'h0, '0, 4'h0, 0, 1'b0);
    cyc0(4'hF, d, 4'b0100, 0, 1'b0);
    cyc0(4'b0001, d, 4'b0001, 1, 1'b0);

    // Async reset with two tags in flight.
    rv0 = 4'h0;
    #1;
    chk("pre_rst_inflight", 32'(inf0), 32'd2);
    #2 reset_n = 1'b0;
    rv0 = 4'hF;
    #1;
    chk("arst_rsp_valid", 32'(sv0), 32'h0);
    chk("arst_inflight", 32'(inf0), 32'h0);
    chk("arst_req_ready", 32'(rr0), 32'h0);
    chk("arst_dp_valid", 32'(dv0), 32'h0);
    q0.delete();
    @(posedge clk);
    #1;
    chk("arst_edge_inflight", 32'(inf0), 32'h0);
    chk("arst_edge_rsp", 32'(sv0), 32'h0);
    #3 reset_n = 1'b1;
    rv0 = 4'h0;
    @(posedge clk);
    #1;
    d = {10'h2F0, 10'h1E1, 10'h0D2, 10'h3C3};
    cyc0(4'b1001, d, 4'b0001, 0, 1'b0);
    cyc0(4'h0, '0, 4'h0, 1, 1'b0);
    cyc0(4'h0, '0, 4'h0, 1, 1'b0);
    cyc0(4'h0, '0, 4'h0, 1, 1'b0);
    cyc0(4'h0, '0, 4'h0, 0, 1'b0);

    // LATENCY=1: requesters 1 and 3 alternate, each answered next edge.
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) d[k*10 +: 10] = 10'(101 * j + 13 * k + 7);
      cyc1(4'b1010, d, (j % 2 == 0) ? 4'b0010 : 4'b1000, (j == 0) ? 0 : 1);
    end
    cyc1(4'h0, '0, 4'h0, 1);
    cyc1(4'h0, '0, 4'h0, 0);
    cyc1(4'h0, '0, 4'h0, 0);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
